// File: rtl/tank_ctrl_pkg.sv
// Shared types and helpers for the tank level pump controller.
// Holds the FSM state encoding, fault code values and the bit-vector
// helpers used to derive the level count and validate probe patterns.
package tank_ctrl_pkg;

    // Widest probe vector the helper functions accept
    localparam int MAX_SENSORS = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FILL     = 2'd1,
        COOLDOWN = 2'd2,
        FAULT    = 2'd3
    } state_t;

    localparam logic [1:0] FC_NONE  = 2'd0;
    localparam logic [1:0] FC_DRY   = 2'd1;
    localparam logic [1:0] FC_PROBE = 2'd2;

    localparam logic [MAX_SENSORS:0] ONE_EXT = {{MAX_SENSORS{1'b0}}, 1'b1};

    // Number of set bits in a zero-extended probe vector
    function automatic logic [5:0] popcount(input logic [MAX_SENSORS-1:0] v);
        logic [5:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_SENSORS; i++) begin
            cnt = cnt + {5'b0, v[i]};
        end
        return cnt;
    endfunction

    // True when no 0 sits below a 1, i.e. the vector is 0...01...1.
    // Adding one to a valid pattern carries through every set bit, so the
    // AND with the original is zero only for thermometer code.
    function automatic logic is_thermometer(input logic [MAX_SENSORS-1:0] v);
        logic [MAX_SENSORS:0] w;
        w = {1'b0, v};
        return ((w & (w + ONE_EXT)) == '0);
    endfunction

endpackage

// File: rtl/level_probe_debouncer.sv
// Single probe conditioning: 2-flop synchroniser followed by a stability
// counter. The output only follows the synchronised input after it has
// disagreed with the current output for DEBOUNCE_CYCLES consecutive cycles.
module level_probe_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic deb
);

    localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);

    logic          sync1_q;
    logic          sync2_q;
    logic          deb_q;
    logic [CW-1:0] cnt_q;

    // Synchronise the raw probe, then accept a new level only after it has
    // been held long enough; any return to the old level restarts the count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            if (sync2_q != deb_q) begin
                if (cnt_q == CNT_LAST) begin
                    deb_q <= sync2_q;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign deb = deb_q;

endmodule

// File: rtl/tank_level_pump_ctrl.sv
// Tank level pump controller: debounces N thermometer-coded probes, keeps
// the pump between START_LEVEL and STOP_LEVEL with hysteresis, enforces a
// minimum off time and latches dry-run / probe-inconsistency faults.
// Optional build macro MANUAL_OVERRIDE_EN adds a manual_on input that runs
// the pump from IDLE or COOLDOWN while the tank is below STOP_LEVEL.
module tank_level_pump_ctrl
    import tank_ctrl_pkg::*;
#(
    parameter int NUM_SENSORS     = 3,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int START_LEVEL     = 1,
    parameter int STOP_LEVEL      = 3,
    parameter int MIN_OFF_CYCLES  = 8,
    parameter int FILL_TIMEOUT    = 50
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_SENSORS-1:0]           level,
    input  logic                             fault_clr,
`ifdef MANUAL_OVERRIDE_EN
    input  logic                             manual_on,
`endif
    output logic                             motor_on,
    output logic [$clog2(NUM_SENSORS+1)-1:0] level_count,
    output logic [1:0]                       state,
    output logic                             fault,
    output logic [1:0]                       fault_code
);

    localparam int LCW      = $clog2(NUM_SENSORS + 1);
    localparam int TMAX_VAL = (MIN_OFF_CYCLES > FILL_TIMEOUT) ? MIN_OFF_CYCLES : FILL_TIMEOUT;
    localparam int TW       = (TMAX_VAL < 1) ? 1 : $clog2(TMAX_VAL + 1);

    localparam logic [LCW-1:0] START_C   = LCW'(START_LEVEL);
    localparam logic [LCW-1:0] STOP_C    = LCW'(STOP_LEVEL);
    localparam logic [TW-1:0]  FILL_LAST = TW'((FILL_TIMEOUT > 0) ? FILL_TIMEOUT - 1 : 0);
    localparam logic [TW-1:0]  OFF_LAST  = TW'((MIN_OFF_CYCLES > 0) ? MIN_OFF_CYCLES - 1 : 0);
    localparam logic [TW-1:0]  TMAX_C    = {TW{1'b1}};

    logic [NUM_SENSORS-1:0] deb_vec;
    logic [MAX_SENSORS-1:0] deb_ext;
    logic [LCW-1:0]         level_count_q;
    logic [LCW-1:0]         last_count_q;
    logic                   probe_err_q;
    logic                   manual_ok;
    state_t                 state_q;
    logic                   motor_on_q;
    logic                   fault_q;
    logic [1:0]             fault_code_q;
    logic [TW-1:0]          timer_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SENSORS; gi++) begin : g_probe
            level_probe_debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clk  (clk),
                .reset(reset),
                .raw  (level[gi]),
                .deb  (deb_vec[gi])
            );
        end
    endgenerate

    // Widen the debounced vector to the helper functions' fixed width
    always_comb begin
        deb_ext                  = '0;
        deb_ext[NUM_SENSORS-1:0] = deb_vec;
    end

`ifdef MANUAL_OVERRIDE_EN
    assign manual_ok = manual_on && (level_count_q < STOP_C);
`else
    assign manual_ok = 1'b0;
`endif

    // Register the level count and the probe-pattern check together so the
    // FSM sees both on the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_count_q <= '0;
            probe_err_q   <= 1'b0;
        end else begin
            level_count_q <= LCW'(popcount(deb_ext));
            probe_err_q   <= !is_thermometer(deb_ext);
        end
    end

    // Pump FSM; one shared timer serves as fill watchdog and cooldown counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            motor_on_q   <= 1'b0;
            fault_q      <= 1'b0;
            fault_code_q <= FC_NONE;
            timer_q      <= '0;
            last_count_q <= '0;
        end else begin
            last_count_q <= level_count_q;
            if (probe_err_q) begin
                // Bad probe pattern wins over everything, including fault_clr
                state_q      <= FAULT;
                motor_on_q   <= 1'b0;
                fault_q      <= 1'b1;
                fault_code_q <= FC_PROBE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (level_count_q < START_C) begin
                            state_q    <= FILL;
                            motor_on_q <= 1'b1;
                            timer_q    <= '0;
                        end else begin
                            motor_on_q <= manual_ok;
                        end
                    end
                    FILL: begin
                        if (level_count_q >= STOP_C) begin
                            state_q    <= COOLDOWN;
                            motor_on_q <= manual_ok;
                            timer_q    <= '0;
                        end else if (level_count_q > last_count_q) begin
                            // Water is still rising: restart the watchdog
                            motor_on_q <= 1'b1;
                            timer_q    <= '0;
                        end else if (timer_q >= FILL_LAST) begin
                            state_q      <= FAULT;
                            motor_on_q   <= 1'b0;
                            fault_q      <= 1'b1;
                            fault_code_q <= FC_DRY;
                        end else begin
                            motor_on_q <= 1'b1;
                            if (timer_q != TMAX_C) begin
                                timer_q <= timer_q + TW'(1);
                            end
                        end
                    end
                    COOLDOWN: begin
                        motor_on_q <= manual_ok;
                        if (timer_q >= OFF_LAST) begin
                            state_q <= IDLE;
                            timer_q <= '0;
                        end else begin
                            timer_q <= timer_q + TW'(1);
                        end
                    end
                    default: begin
                        motor_on_q <= 1'b0;
                        if (fault_clr) begin
                            state_q      <= IDLE;
                            fault_q      <= 1'b0;
                            fault_code_q <= FC_NONE;
                            timer_q      <= '0;
                        end
                    end
                endcase
            end
        end
    end

    assign motor_on    = motor_on_q;
    assign level_count = level_count_q;
    assign state       = state_q;
    assign fault       = fault_q;
    assign fault_code  = fault_code_q;

endmodule

// File: tb/tb_tank_level_pump_ctrl.sv
// Directed bench for tank_level_pump_ctrl with default parameters.
// Expected output snapshots are queued when a step is driven and checked
// when the step's wait elapses.
module tb_tank_level_pump_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] level;
    logic       fault_clr;
`ifdef MANUAL_OVERRIDE_EN
    logic       manual_on;
`endif
    logic       motor_on;
    logic [1:0] level_count;
    logic [1:0] state;
    logic       fault;
    logic [1:0] fault_code;

    string      tag_q[$];
    logic [7:0] exp_q[$];
    int         n_assert = 0;
    int         n_fail   = 0;

    tank_level_pump_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .level      (level),
        .fault_clr  (fault_clr),
`ifdef MANUAL_OVERRIDE_EN
        .manual_on  (manual_on),
`endif
        .motor_on   (motor_on),
        .level_count(level_count),
        .state      (state),
        .fault      (fault),
        .fault_code (fault_code)
    );

    always #5 clk = ~clk;

    // Packed snapshot: {state, motor_on, fault, fault_code, level_count}
    function automatic logic [7:0] pk(input logic [1:0] st, input logic m, input logic f,
                                      input logic [1:0] c, input logic [1:0] n);
        return {st, m, f, c, n};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string t, input logic [7:0] e);
        tag_q.push_back(t);
        exp_q.push_back(e);
    endtask

    task automatic check_out();
        string      t;
        logic [7:0] e;
        logic [7:0] o;
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        o = {state, motor_on, fault, fault_code, level_count};
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $display("FAIL %s: observed st=%0d motor=%0b fault=%0b code=%0d cnt=%0d expected st=%0d motor=%0b fault=%0b code=%0d cnt=%0d",
                     t, o[7:6], o[5], o[4], o[3:2], o[1:0], e[7:6], e[5], e[4], e[3:2], e[1:0]);
            $error("check %s did not match", t);
        end
        $display("t=%0t %-22s st=%0d motor=%0b fault=%0b code=%0d cnt=%0d",
                 $time, t, o[7:6], o[5], o[4], o[3:2], o[1:0]);
    endtask

    // Queue an expectation, let n cycles elapse, then compare
    task automatic expect_after(input string t, input logic [7:0] e, input int n);
        push_exp(t, e);
        if (n > 0) tick(n);
        check_out();
    endtask

    initial begin
        reset     = 1'b1;
        level     = 3'b000;
        fault_clr = 1'b0;
`ifdef MANUAL_OVERRIDE_EN
        manual_on = 1'b0;
`endif
        tick(3);
        expect_after("reset_state", pk(0, 0, 0, 0, 0), 0);

        // Empty tank: IDLE starts the pump on the first cycle out of reset
        reset = 1'b0;
        expect_after("fill_after_reset", pk(1, 1, 0, 0, 0), 1);
        expect_after("count0_after_latency", pk(1, 1, 0, 0, 0), 6);

        // Rising level, 20 cycles per step; count follows 7 cycles after the raw edge
        level = 3'b001;
        expect_after("lvl1_before_latency", pk(1, 1, 0, 0, 0), 6);
        expect_after("lvl1", pk(1, 1, 0, 0, 1), 1);
        tick(13);
        level = 3'b011;
        expect_after("lvl2", pk(1, 1, 0, 0, 2), 7);
        tick(13);
        level = 3'b111;
        expect_after("lvl3_motor_still_on", pk(1, 1, 0, 0, 3), 7);
        expect_after("stop_cooldown", pk(2, 0, 0, 0, 3), 1);

        // Drain during cooldown: pump stays off for the full 8 cycles
        tick(1);
        level = 3'b000;
        expect_after("cooldown_last", pk(2, 0, 0, 0, 3), 6);
        expect_after("cooldown_done_idle", pk(0, 0, 0, 0, 0), 1);
        expect_after("refill", pk(1, 1, 0, 0, 0), 1);

        // Dry run: FILL lasts exactly FILL_TIMEOUT cycles without a rise
        expect_after("dry_last_fill", pk(1, 1, 0, 0, 0), 49);
        expect_after("dry_fault", pk(3, 0, 1, 1, 0), 1);
        expect_after("fault_held", pk(3, 0, 1, 1, 0), 3);
        fault_clr = 1'b1;
        expect_after("clr_idle", pk(0, 0, 0, 0, 0), 1);
        fault_clr = 1'b0;
        expect_after("clr_refill", pk(1, 1, 0, 0, 0), 1);
        fault_clr = 1'b1;
        expect_after("clr_ignored_in_fill", pk(1, 1, 0, 0, 0), 1);
        fault_clr = 1'b0;

        // Non-thermometer pattern 101
        level = 3'b101;
        expect_after("probe_cnt", pk(1, 1, 0, 0, 2), 7);
        expect_after("probe_fault", pk(3, 0, 1, 2, 2), 1);
        fault_clr = 1'b1;
        expect_after("clr_blocked_by_probe", pk(3, 0, 1, 2, 2), 1);
        fault_clr = 1'b0;
        level = 3'b000;
        expect_after("probe_gone_held", pk(3, 0, 1, 2, 0), 7);
        fault_clr = 1'b1;
        expect_after("clr_idle2", pk(0, 0, 0, 0, 0), 1);
        fault_clr = 1'b0;
        expect_after("fill3", pk(1, 1, 0, 0, 0), 1);

        // Probe 0 bouncing every 2 cycles never passes the debouncer
        for (int i = 0; i < 12; i++) begin
            level = (i % 2 == 0) ? 3'b001 : 3'b000;
            expect_after("bounce", pk(1, 1, 0, 0, 0), 2);
        end
        expect_after("bounce_settled", pk(1, 1, 0, 0, 0), 8);

        // Asynchronous reset in the middle of FILL
        level = 3'b001;
        expect_after("pre_reset_cnt", pk(1, 1, 0, 0, 1), 7);
        reset = 1'b1;
        #1;
        expect_after("async_reset", pk(0, 0, 0, 0, 0), 0);
        tick(1);
        reset = 1'b0;
        expect_after("post_reset_fill", pk(1, 1, 0, 0, 0), 1);
        expect_after("post_reset_cnt0", pk(1, 1, 0, 0, 0), 5);
        expect_after("post_reset_cnt1", pk(1, 1, 0, 0, 1), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
